// File: rtl/can_fd_tx_bit_stuffer.sv
// Transmit-side CAN FD bit stuffer: dynamic stuffing over SOF..data, fixed
// stuff bits in the FD CRC field and the ISO stuff-count field.
module can_fd_tx_bit_stuffer #(
    parameter int unsigned RUN_LEN    = 5,
    parameter int unsigned FSB_PERIOD = 4
) (
    input  logic       clk_i,
    input  logic       reg_rst_i,
    input  logic       tx_point_i,
    input  logic       start_i,
    input  logic       iso_i,
    input  logic       bit_valid_i,
    input  logic       bit_i,
    input  logic [1:0] mode_i,
    output logic       bit_ready_o,
    output logic       tx_o,
    output logic       stuff_bit_o,
    output logic [2:0] stuff_cnt_o,
    output logic       underrun_o
);

    localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);
    localparam int unsigned FSB_W = $clog2(FSB_PERIOD + 1);
    localparam int unsigned SC_W  = 2;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_DYN   = 2'b01;
    localparam logic [1:0] MODE_FIXED = 2'b10;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_SC,
        ST_FSB
    } state_t;

    state_t           state, state_n, cur_state;
    logic [RUN_W-1:0] run, run_n, cur_run;
    logic [FSB_W-1:0] fsb_cnt, fsb_n, cur_fsb;
    logic [SC_W-1:0]  sc_idx, sc_idx_n;
    logic [1:0]       last_mode, last_mode_n, cur_lmode;
    logic [2:0]       cur_cnt, stuff_cnt_n, gray;
    logic [3:0]       sc_seq;
    logic             tx_n, stuff_bit_n, underrun_n;
    logic             fixed_in, dyn_due, fix_entry, fix_cont;

    always_comb begin
        // start_i clears the frame context before this cycle's tx_point is processed
        cur_state = start_i ? ST_DATA : state;
        cur_run   = start_i ? '0 : run;
        cur_fsb   = start_i ? '0 : fsb_cnt;
        cur_lmode = start_i ? MODE_NONE : last_mode;
        cur_cnt   = start_i ? 3'd0 : stuff_cnt_o;

        gray   = {cur_cnt[2], cur_cnt[2] ^ cur_cnt[1], cur_cnt[1] ^ cur_cnt[0]};
        sc_seq = {^gray, gray[0], gray[1], gray[2]};

        fixed_in  = bit_valid_i && (mode_i == MODE_FIXED);
        dyn_due   = (cur_lmode == MODE_DYN) && (cur_run == RUN_W'(RUN_LEN)) && !fixed_in;
        fix_entry = fixed_in && (cur_lmode != MODE_FIXED);
        fix_cont  = fixed_in && (cur_fsb == FSB_W'(FSB_PERIOD));

        bit_ready_o = (cur_state == ST_DATA) && !dyn_due && !fix_entry && !fix_cont;

        state_n     = cur_state;
        run_n       = cur_run;
        fsb_n       = cur_fsb;
        sc_idx_n    = sc_idx;
        last_mode_n = cur_lmode;
        stuff_cnt_n = cur_cnt;
        tx_n        = tx_o;
        stuff_bit_n = stuff_bit_o;
        underrun_n  = 1'b0;

        if (tx_point_i) begin
            case (cur_state)
                ST_DATA: begin
                    if (dyn_due) begin
                        tx_n        = ~tx_o;
                        stuff_bit_n = 1'b1;
                        stuff_cnt_n = cur_cnt + 3'd1;
                        run_n       = RUN_W'(1);
                    end else if (fix_entry) begin
                        // the entry FSB already belongs to the FIXED field
                        tx_n        = ~tx_o;
                        stuff_bit_n = 1'b1;
                        fsb_n       = '0;
                        run_n       = '0;
                        last_mode_n = MODE_FIXED;
                        sc_idx_n    = '0;
                        state_n     = iso_i ? ST_SC : ST_DATA;
                    end else if (fix_cont) begin
                        tx_n        = ~tx_o;
                        stuff_bit_n = 1'b1;
                        fsb_n       = '0;
                        run_n       = '0;
                    end else if (!bit_valid_i) begin
                        tx_n        = 1'b1;
                        stuff_bit_n = 1'b0;
                        underrun_n  = 1'b1;
                    end else begin
                        tx_n        = bit_i;
                        stuff_bit_n = 1'b0;
                        last_mode_n = (mode_i == MODE_DYN || mode_i == MODE_FIXED) ? mode_i : MODE_NONE;
                        if (mode_i == MODE_DYN) begin
                            if (bit_i != tx_o)                   run_n = RUN_W'(1);
                            else if (cur_run != RUN_W'(RUN_LEN)) run_n = cur_run + RUN_W'(1);
                        end else begin
                            run_n = '0;
                        end
                        if (mode_i == MODE_FIXED) fsb_n = cur_fsb + FSB_W'(1);
                    end
                end
                ST_SC: begin
                    tx_n        = sc_seq[sc_idx];
                    stuff_bit_n = 1'b1;
                    fsb_n       = cur_fsb + FSB_W'(1);
                    run_n       = '0;
                    sc_idx_n    = sc_idx + SC_W'(1);
                    if (sc_idx == SC_W'(3)) state_n = ST_FSB;
                end
                ST_FSB: begin
                    tx_n        = ~tx_o;
                    stuff_bit_n = 1'b1;
                    fsb_n       = '0;
                    run_n       = '0;
                    state_n     = ST_DATA;
                end
                default: state_n = ST_DATA;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reg_rst_i) begin
            state       <= ST_DATA;
            run         <= '0;
            fsb_cnt     <= '0;
            sc_idx      <= '0;
            last_mode   <= MODE_NONE;
            tx_o        <= 1'b1;
            stuff_bit_o <= 1'b0;
            stuff_cnt_o <= 3'd0;
            underrun_o  <= 1'b0;
        end else begin
            state       <= state_n;
            run         <= run_n;
            fsb_cnt     <= fsb_n;
            sc_idx      <= sc_idx_n;
            last_mode   <= last_mode_n;
            tx_o        <= tx_n;
            stuff_bit_o <= stuff_bit_n;
            stuff_cnt_o <= stuff_cnt_n;
            underrun_o  <= underrun_n;
        end
    end

endmodule

// File: tb/tb_can_fd_tx_bit_stuffer.sv
// Bench for can_fd_tx_bit_stuffer: directed vector tables for the named
// scenarios plus random frames checked against a bit-stream reference model.
module tb_can_fd_tx_bit_stuffer;

    localparam int RUN_LEN    = 5;
    localparam int FSB_PERIOD = 4;
    localparam logic [1:0] M_NONE = 2'b00;
    localparam logic [1:0] M_DYN  = 2'b01;
    localparam logic [1:0] M_FIX  = 2'b10;
    localparam logic [1:0] M_RSV  = 2'b11;

    logic       clk_i = 1'b0;
    logic       reg_rst_i, tx_point_i, start_i, iso_i, bit_valid_i, bit_i;
    logic [1:0] mode_i;
    logic       bit_ready_o, tx_o, stuff_bit_o, underrun_o;
    logic [2:0] stuff_cnt_o;

    always #5 clk_i = ~clk_i;

    can_fd_tx_bit_stuffer #(.RUN_LEN(RUN_LEN), .FSB_PERIOD(FSB_PERIOD)) dut (
        .clk_i       (clk_i),
        .reg_rst_i   (reg_rst_i),
        .tx_point_i  (tx_point_i),
        .start_i     (start_i),
        .iso_i       (iso_i),
        .bit_valid_i (bit_valid_i),
        .bit_i       (bit_i),
        .mode_i      (mode_i),
        .bit_ready_o (bit_ready_o),
        .tx_o        (tx_o),
        .stuff_bit_o (stuff_bit_o),
        .stuff_cnt_o (stuff_cnt_o),
        .underrun_o  (underrun_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // one tx_point cycle; ready is sampled before the edge, outputs after it
    task automatic tp(input logic st, input logic iso, input logic v, input logic b,
                      input logic [1:0] m, output logic rdy);
        start_i = st; iso_i = iso; bit_valid_i = v; bit_i = b; mode_i = m;
        tx_point_i = 1'b1;
        #1 rdy = bit_ready_o;
        @(posedge clk_i); #1;
        tx_point_i = 1'b0;
        start_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        reg_rst_i = 1'b1;
        @(posedge clk_i); #1;
        reg_rst_i = 1'b0;
    endtask

    // present one bit value repeatedly until n bits have been consumed
    task automatic feed(input logic b, input logic [1:0] m, input int n, input logic iso,
                        output int stuffs);
        logic rdy;
        int   got   = 0;
        int   guard = 0;
        stuffs = 0;
        while (got < n && guard < 4 * n + 8) begin
            tp(1'b0, iso, 1'b1, b, m, rdy);
            if (rdy) got++;
            if (stuff_bit_o) stuffs++;
            guard++;
        end
        check("feed consumed", got, n);
    endtask

    typedef struct {
        int         seg;
        logic       st, iso, v, b;
        logic [1:0] m;
        logic       tx, sb, rdy;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int seg, input logic st, input logic iso, input logic v, input logic b,
                       input logic [1:0] m, input logic tx, input logic sb, input logic rdy);
        vec_t r;
        r.seg = seg; r.st = st; r.iso = iso; r.v = v; r.b = b; r.m = m;
        r.tx = tx; r.sb = sb; r.rdy = rdy;
        tbl.push_back(r);
    endtask

    task automatic run_seg(input int seg);
        logic rdy;
        foreach (tbl[i]) begin
            if (tbl[i].seg == seg) begin
                tp(tbl[i].st, tbl[i].iso, tbl[i].v, tbl[i].b, tbl[i].m, rdy);
                check($sformatf("seg%0d[%0d] ready", seg, i), rdy, tbl[i].rdy);
                check($sformatf("seg%0d[%0d] tx", seg, i), tx_o, tbl[i].tx);
                check($sformatf("seg%0d[%0d] stuff", seg, i), stuff_bit_o, tbl[i].sb);
            end
        end
    endtask

    // reference model: expands frame bits into the expected serial stream
    typedef struct {
        logic tx, sb, is_data;
    } exp_t;
    exp_t exp_q[$];
    int   gray_tbl[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    logic m_last;
    int   m_run, m_cnt, m_fsb;
    logic [1:0] m_lmode;

    task automatic emit(input logic t, input logic sb, input logic d);
        exp_t e;
        e.tx = t; e.sb = sb; e.is_data = d;
        exp_q.push_back(e);
        m_last = t;
    endtask

    task automatic model_bit(input logic b, input logic [1:0] m, input logic iso);
        logic [2:0] g;
        if (m == M_FIX && m_lmode != M_FIX) begin
            emit(~m_last, 1'b1, 1'b0);
            if (iso) begin
                g = 3'(gray_tbl[m_cnt % 8]);
                emit(g[2], 1'b1, 1'b0);
                emit(g[1], 1'b1, 1'b0);
                emit(g[0], 1'b1, 1'b0);
                emit(1'($countones(g) % 2), 1'b1, 1'b0);
                emit(~m_last, 1'b1, 1'b0);
            end
            m_fsb = 0;
            m_run = 0;
        end else if (m != M_FIX && m_lmode == M_DYN && m_run == RUN_LEN) begin
            emit(~m_last, 1'b1, 1'b0);
            m_cnt++;
            m_run = 1;
        end else if (m == M_FIX && m_fsb == FSB_PERIOD) begin
            emit(~m_last, 1'b1, 1'b0);
            m_fsb = 0;
        end
        if (m == M_DYN) m_run = (b == m_last) ? ((m_run < RUN_LEN) ? m_run + 1 : m_run) : 1;
        else            m_run = 0;
        if (m == M_FIX) m_fsb++;
        m_lmode = (m == M_RSV) ? M_NONE : m;
        emit(b, 1'b0, 1'b1);
    endtask

    logic       fb_q[$];
    logic [1:0] fm_q[$];
    logic       rdy, f_iso, f_tpstart, first, prev, v, b;
    logic [1:0] m;
    int         s, guard, n_dyn, n_fix, n_none;
    exp_t       e;

    initial begin
        reg_rst_i = 1'b1; tx_point_i = 1'b0; start_i = 1'b0; iso_i = 1'b0;
        bit_valid_i = 1'b0; bit_i = 1'b0; mode_i = M_NONE;

        // scenario 1: run of six 0s
        add(1, 1, 0, 1, 0, M_DYN, 0, 0, 1);
        repeat (4) add(1, 0, 0, 1, 0, M_DYN, 0, 0, 1);
        add(1, 0, 0, 1, 0, M_DYN, 1, 1, 0);
        add(1, 0, 0, 1, 0, M_DYN, 0, 0, 1);
        add(1, 0, 0, 1, 1, M_DYN, 1, 0, 1);
        // scenario 2: ten 1s, stuff bit counts toward the next run, DYN->NONE stuff
        add(2, 1, 0, 1, 1, M_DYN, 1, 0, 1);
        repeat (4) add(2, 0, 0, 1, 1, M_DYN, 1, 0, 1);
        add(2, 0, 0, 1, 1, M_DYN, 0, 1, 0);
        repeat (5) add(2, 0, 0, 1, 1, M_DYN, 1, 0, 1);
        add(2, 0, 0, 1, 1, M_NONE, 0, 1, 0);
        add(2, 0, 0, 1, 1, M_NONE, 1, 0, 1);
        // scenario 3: ISO CRC field, stuff count 3
        add(3, 0, 1, 1, 1, M_FIX, 0, 1, 0);
        add(3, 0, 1, 1, 1, M_FIX, 0, 1, 0);
        add(3, 0, 1, 1, 1, M_FIX, 1, 1, 0);
        add(3, 0, 1, 1, 1, M_FIX, 0, 1, 0);
        add(3, 0, 1, 1, 1, M_FIX, 1, 1, 0);
        add(3, 0, 1, 1, 1, M_FIX, 0, 1, 0);
        add(3, 0, 1, 1, 1, M_FIX, 1, 0, 1);
        add(3, 0, 1, 1, 0, M_FIX, 0, 0, 1);
        add(3, 0, 1, 1, 1, M_FIX, 1, 0, 1);
        add(3, 0, 1, 1, 1, M_FIX, 1, 0, 1);
        add(3, 0, 1, 1, 0, M_FIX, 0, 1, 0);
        add(3, 0, 1, 1, 0, M_FIX, 0, 0, 1);
        // scenario 4: non-ISO, same CRC bits
        add(4, 0, 0, 1, 1, M_FIX, 0, 1, 0);
        add(4, 0, 0, 1, 1, M_FIX, 1, 0, 1);
        add(4, 0, 0, 1, 0, M_FIX, 0, 0, 1);
        add(4, 0, 0, 1, 1, M_FIX, 1, 0, 1);
        add(4, 0, 0, 1, 1, M_FIX, 1, 0, 1);
        add(4, 0, 0, 1, 0, M_FIX, 0, 1, 0);
        add(4, 0, 0, 1, 0, M_FIX, 0, 0, 1);
        // scenario 5: pending dynamic stuff dropped on FIXED, kept on NONE
        add(5, 0, 0, 1, 1, M_FIX, 1, 1, 0);
        add(5, 0, 0, 1, 1, M_FIX, 1, 0, 1);
        add(6, 0, 0, 1, 0, M_NONE, 1, 1, 0);
        add(6, 0, 0, 1, 0, M_NONE, 0, 0, 1);

        idle(2);
        #1;
        check("reset tx", tx_o, 1);
        check("reset stuff", stuff_bit_o, 0);
        check("reset cnt", stuff_cnt_o, 0);
        check("reset underrun", underrun_o, 0);
        check("reset ready", bit_ready_o, 1);
        reg_rst_i = 1'b0;
        idle(1);

        run_seg(1);
        check("s1 cnt", stuff_cnt_o, 1);
        run_seg(2);
        check("s2 cnt", stuff_cnt_o, 2);

        do_start();
        feed(1'b1, M_DYN, 16, 1'b1, s);
        check("s3 prelude stuffs", s, 3);
        check("s3 prelude cnt", stuff_cnt_o, 3);
        run_seg(3);
        check("s3 cnt", stuff_cnt_o, 3);

        do_start();
        feed(1'b1, M_DYN, 16, 1'b0, s);
        check("s4 prelude stuffs", s, 3);
        run_seg(4);
        check("s4 cnt", stuff_cnt_o, 3);

        do_start();
        feed(1'b0, M_DYN, 5, 1'b0, s);
        run_seg(5);
        check("s5 fixed cnt", stuff_cnt_o, 0);
        do_start();
        feed(1'b0, M_DYN, 5, 1'b0, s);
        run_seg(6);
        check("s5 none cnt", stuff_cnt_o, 1);

        // underrun at a ready tx_point
        tp(1'b0, 1'b0, 1'b0, 1'b0, M_NONE, rdy);
        check("underrun ready", rdy, 1);
        check("underrun tx", tx_o, 1);
        check("underrun stuff", stuff_bit_o, 0);
        check("underrun pulse", underrun_o, 1);
        idle(1);
        check("underrun pulse end", underrun_o, 0);
        check("underrun cnt", stuff_cnt_o, 1);

        // reset in the middle of the stuff-count field
        tp(1'b0, 1'b1, 1'b1, 1'b1, M_FIX, rdy);
        check("midsc fsb tx", tx_o, 0);
        tp(1'b0, 1'b1, 1'b1, 1'b1, M_FIX, rdy);
        check("midsc sc stuff", stuff_bit_o, 1);
        check("midsc sc ready", rdy, 0);
        reg_rst_i = 1'b1; tx_point_i = 1'b1;
        @(posedge clk_i); #1;
        reg_rst_i = 1'b0; tx_point_i = 1'b0; bit_valid_i = 1'b0;
        #1;
        check("midsc rst tx", tx_o, 1);
        check("midsc rst stuff", stuff_bit_o, 0);
        check("midsc rst cnt", stuff_cnt_o, 0);
        check("midsc rst ready", bit_ready_o, 1);

        // nine dynamic stuffs wrap the counter
        do_start();
        feed(1'b0, M_DYN, 45, 1'b0, s);
        check("wrap stuffs", s, 8);
        tp(1'b0, 1'b0, 1'b1, 1'b0, M_DYN, rdy);
        check("wrap 9th stuff", stuff_bit_o, 1);
        check("wrap cnt", stuff_cnt_o, 1);

        // random frames against the reference model
        do_reset();
        m_last = 1'b1;
        for (int f = 0; f < 40; f++) begin
            f_iso     = 1'($urandom_range(0, 1));
            f_tpstart = 1'($urandom_range(0, 1));
            n_dyn     = $urandom_range(1, 40);
            n_fix     = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 21);
            n_none    = $urandom_range(1, 4);
            fb_q.delete(); fm_q.delete(); exp_q.delete();
            prev = 1'($urandom_range(0, 1));
            for (int i = 0; i < n_dyn; i++) begin
                if ($urandom_range(0, 4) == 0) prev = ~prev;
                fb_q.push_back(prev); fm_q.push_back(M_DYN);
            end
            for (int i = 0; i < n_fix; i++) begin
                fb_q.push_back(1'($urandom_range(0, 1))); fm_q.push_back(M_FIX);
            end
            for (int i = 0; i < n_none; i++) begin
                fb_q.push_back(1'($urandom_range(0, 1)));
                fm_q.push_back(($urandom_range(0, 3) == 0) ? M_RSV : M_NONE);
            end
            m_run = 0; m_cnt = 0; m_fsb = 0; m_lmode = M_NONE;
            foreach (fb_q[i]) model_bit(fb_q[i], fm_q[i], f_iso);

            if (!f_tpstart) do_start();
            first = 1'b1;
            guard = 0;
            while (exp_q.size() > 0 && guard < 400) begin
                idle($urandom_range(0, 2));
                v = (fb_q.size() > 0);
                b = v ? fb_q[0] : 1'b1;
                m = v ? fm_q[0] : M_NONE;
                tp(first && f_tpstart, f_iso, v, b, m, rdy);
                first = 1'b0;
                e = exp_q.pop_front();
                check($sformatf("rnd f%0d ready", f), rdy, e.is_data);
                check($sformatf("rnd f%0d tx", f), tx_o, e.tx);
                check($sformatf("rnd f%0d stuff", f), stuff_bit_o, e.sb);
                if (rdy && v) begin
                    void'(fb_q.pop_front());
                    void'(fm_q.pop_front());
                end
                guard++;
            end
            check($sformatf("rnd f%0d drained", f), exp_q.size(), 0);
            check($sformatf("rnd f%0d cnt", f), stuff_cnt_o, m_cnt % 8);
            tp(1'b0, f_iso, 1'b0, 1'b0, M_NONE, rdy);
            check($sformatf("rnd f%0d underrun", f), underrun_o, 1);
            check($sformatf("rnd f%0d underrun tx", f), tx_o, 1);
            m_last = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_fd_tx_bit_stuffer.md
Name: can_fd_tx_bit_stuffer

Overview:
Transmit-side bit-stream encoder for the CAN FD controller. It sits between the TX frame generator and the bit-timing/TX pin logic, and is the counterpart of the receive-side destuffer. It applies dynamic stuffing over SOF..data. For FD frames it inserts fixed stuff bits in the CRC field. In ISO mode it also generates and inserts the stuff-count field (gray code plus parity).

Parameters:
RUN_LEN, 5, equal consecutive bits that trigger a dynamic stuff bit
FSB_PERIOD, 4, fixed-mode bits between fixed stuff bits

Ports:
clk_i  input  1  system clock; all logic on rising edge
reg_rst_i  input  1  synchronous active-high reset
tx_point_i  input  1  one-cycle pulse at each bit transmit point (nominal or data rate)
start_i  input  1  one-cycle pulse before SOF; clears run length, stuff counter, FSB counter and state
iso_i  input  1  1 = ISO CAN FD (stuff count inserted), 0 = non-ISO; sampled on FIXED entry
bit_valid_i  input  1  generator presents the next frame bit
bit_i  input  1  next frame bit
mode_i  input  2  stuffing mode of presented bit: 00 NONE, 01 DYN, 10 FIXED, 11 reserved (= NONE)
bit_ready_o  output  1  combinational; block consumes the presented bit at the next tx_point_i
tx_o  output  1  registered serial output; 1 = recessive
stuff_bit_o  output  1  registered; 1 while tx_o carries an inserted bit (dynamic/fixed stuff or stuff-count bit)
stuff_cnt_o  output  3  dynamic stuff bits inserted this frame, mod 8
underrun_o  output  1  one-cycle pulse when data is needed and bit_valid_i=0

Behaviour:
- Clock, reset and latency:
  - One clock domain.
  - Reset applies on a clock edge while reg_rst_i=1 and overrides every other input, including mid-frame.
  - Reset values: tx_o=1, stuff_bit_o=0, stuff_cnt_o=0, underrun_o=0, state=DATA.
  - Internal reset values: run=0, last_bit=1, last_mode=NONE, fsb_cnt=0.
  - All state changes only in cycles with tx_point_i=1, except start_i and reset.
  - tx_o and stuff_bit_o update on the edge that ends the tx_point_i cycle (1-cycle latency) and hold until the next tx_point_i.
- Handshake:
  - bit_ready_o=1 exactly when state=DATA and no insertion is pending.
  - A bit is consumed when tx_point_i & bit_ready_o & bit_valid_i.
  - The generator must hold bit_i and mode_i stable until consumed.
- Underrun:
  - Condition: tx_point_i & bit_ready_o & ~bit_valid_i.
  - Response: tx_o=1, stuff_bit_o=0, underrun_o pulse, counters unchanged.
- start_i together with tx_point_i: clear first, then process the tx_point with the cleared state.
- States:
  - DATA: emit the consumed bit.
  - DYN_STUFF: emit ~last_bit, stuff_cnt+1 (wraps 7->0).
  - FSB: emit ~last_bit.
  - SC: emit 4 stuff-count bits g2,g1,g0,p.
- Decision at each tx_point_i in DATA, in priority order:
  1. Dynamic stuff: if last_mode=DYN and run=RUN_LEN and not (bit_valid_i & mode_i=FIXED), emit a dynamic stuff bit. This covers DYN->NONE, where the stuff bit after the last CRC bit of a classic frame is inserted.
  2. FIXED entry: if bit_valid_i & mode_i=FIXED and last_mode!=FIXED, any pending dynamic stuff is dropped and not counted. Emit an FSB. If iso_i=1, next go to SC, then emit another FSB, then DATA. If iso_i=0, next go to DATA.
  3. FIXED continuation: if bit_valid_i & mode_i=FIXED and fsb_cnt=FSB_PERIOD, emit an FSB and clear fsb_cnt.
  4. Otherwise emit the data bit.
- SC field:
  - Gray code of stuff_cnt: 0->000, 1->001, 2->011, 3->010, 4->110, 5->111, 6->101, 7->100.
  - p = g2^g1^g0 (even parity).
  - SC bits and FIXED data bits each increment fsb_cnt.
  - fsb_cnt is set to 0 by every FSB.
- Run tracking applies to every emitted bit in DYN context, stuff bits included:
  - Equal to last_bit: run+1 (saturates at RUN_LEN).
  - Otherwise: run=1.
  - A dynamic stuff bit starts a new run of 1.
- NONE bits set run=0. FIXED, FSB and SC bits set run=0.
- last_bit always tracks tx_o. last_mode is the mode of the last consumed data bit.
- stuff_bit_o=1 for DYN_STUFF, FSB and SC bits.

Test Plan:
1. start_i, then DYN bits 0,0,0,0,0,0,1 -> tx_o 0,0,0,0,0,1,0,1; stuff_bit_o high on the 6th bit only; stuff_cnt_o=1; bit_ready_o=0 during the stuff tx_point.
2. DYN 1 x10 -> tx_o 1,1,1,1,1,0,1,1,1,1,1,0; stuff_cnt_o=2. This proves the stuff bit counts toward run tracking.
3. ISO: stuff_cnt_o=3, last DYN bit 1, then FIXED CRC bits 1,0,1,1,0 -> tx_o 0(FSB),0,1,0(gray 010),1(parity),0(FSB),1,0,1,1,0(FSB),0.
4. Non-ISO, same stimulus as scenario 3 -> tx_o 0(FSB),1,0,1,1,0(FSB),0; no SC bits.
5. Boundary cases:
   - DYN run of five 0s then a FIXED bit -> no dynamic stuff; FSB=1; stuff_cnt_o unchanged.
   - Same run then a NONE bit -> dynamic stuff 1 inserted, stuff_cnt_o+1.
6. Error and wrap cases:
   - bit_valid_i=0 at a ready tx_point -> tx_o=1, underrun_o one pulse.
   - reg_rst_i=1 mid-SC -> tx_o=1, stuff_cnt_o=0, bit_ready_o=1.
   - Nine dynamic stuffs -> stuff_cnt_o=1 (wrap).
